note_tone_gen: RTL and testbench

Parametrised tone generator for the automatic-music path. A note index is loaded with a strobe, looked up in a compile-time table of counter preload codes, and drives a reloading up-counter that produces a 50 %-duty square wave for the speaker. Note changes are applied only at period boundaries, so the output never glitches. Code value all-ones denotes a rest, which silences the output.

---
 rtl/note_tone_gen.sv | 172 +++++++++++++++++
 tb/tb_note_tone_gen.sv | 365 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/note_tone_gen.sv
// rtl/note_tone_gen.sv - Table-driven square-wave note generator with boundary-aligned note changes
//
// Optional feature macro: TONE_OCTAVE_EN (adds the oct port and the octave divider)
//
// Ports:
//   clk       system clock, rising edge
//   rst       synchronous reset, active-high
//   note_ld   single-cycle strobe capturing note_idx (and oct) into the pending register
//   note_idx  requested note index; indices >= NOTES select entry NOTES-1
//   oct       octave-down shift 0..3 (TONE_OCTAVE_EN only)
//   spks      square-wave speaker output
//   tone_act  high while a non-rest note is sounding
//   note_ack  one-cycle pulse when a pending note takes effect
//   cur_idx   note index currently in effect
module note_tone_gen #(
    parameter int NOTES  = 16,
    parameter int IDX_W  = 4,
    parameter int CODE_W = 11,
    parameter logic [NOTES*CODE_W-1:0] TABLE = {
        11'h6C0, 11'h69A, 11'h684, 11'h656, 11'h640, 11'h606, 11'h5C8, 11'h582,
        11'h40C, 11'h390, 11'h305, 11'h69A, 11'h684, 11'h656, 11'h640, 11'h7FF}
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             note_ld,
    input  logic [IDX_W-1:0] note_idx,
`ifdef TONE_OCTAVE_EN
    input  logic [1:0]       oct,
`endif
    output logic             spks,
    output logic             tone_act,
    output logic             note_ack,
    output logic [IDX_W-1:0] cur_idx
);

    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NOTES - 1);
    localparam logic [CODE_W-1:0] ALL_ONES = '1;

    state_t            state;
    state_t            state_nxt;
    logic [CODE_W-1:0] cnt;
    logic [CODE_W-1:0] cur_code;
    logic [CODE_W-1:0] pend_code;
    logic [IDX_W-1:0]  pend_idx;
    logic [IDX_W-1:0]  ld_idx;
    logic              pend;
    logic              pend_rest;
    logic              full;
    logic              apply;
    logic              oct_wrap;

    function automatic logic [CODE_W-1:0] code_of(input logic [IDX_W-1:0] idx);
        return TABLE[int'(idx) * CODE_W +: CODE_W];
    endfunction

    // Clamp at capture time so cur_idx reports the table entry actually played.
    assign ld_idx    = ({{(32-IDX_W){1'b0}}, note_idx} >= 32'(NOTES)) ? LAST_IDX : note_idx;
    assign pend_code = code_of(pend_idx);
    assign pend_rest = (pend_code == ALL_ONES);
    assign full      = (cnt == ALL_ONES);

`ifdef TONE_OCTAVE_EN
    logic [1:0] pend_oct;
    logic [1:0] cur_oct;
    logic [2:0] oct_cnt;

    // Wrap after 2^cur_oct full edges; for cur_oct=3 the shift overflows to 0 and 0-1 gives 7.
    assign oct_wrap = (oct_cnt == ((3'd1 << cur_oct) - 3'd1));
`else
    assign oct_wrap = 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Notes take effect immediately from IDLE, but only on a period boundary while running.
    always_comb begin
        state_nxt = state;
        apply     = 1'b0;
        case (state)
            IDLE: begin
                if (pend) begin
                    apply = 1'b1;
                    if (!pend_rest) begin
                        state_nxt = RUN;
                    end
                end
            end
            RUN: begin
                if (full && pend) begin
                    apply = 1'b1;
                    if (pend_rest) begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt      <= ALL_ONES;
            cur_code <= ALL_ONES;
            spks     <= 1'b0;
            tone_act <= 1'b0;
            note_ack <= 1'b0;
            cur_idx  <= '0;
            pend     <= 1'b0;
            pend_idx <= '0;
`ifdef TONE_OCTAVE_EN
            pend_oct <= '0;
            cur_oct  <= '0;
            oct_cnt  <= '0;
`endif
        end else begin
            note_ack <= apply;
            tone_act <= (state_nxt == RUN);

            // A load on the apply edge becomes the next pending note; the older one is applied now.
            if (note_ld) begin
                pend     <= 1'b1;
                pend_idx <= ld_idx;
`ifdef TONE_OCTAVE_EN
                pend_oct <= oct;
`endif
            end else if (apply) begin
                pend <= 1'b0;
            end

            if (apply) begin
                cur_idx  <= pend_idx;
                cur_code <= pend_code;
`ifdef TONE_OCTAVE_EN
                cur_oct  <= pend_oct;
                oct_cnt  <= '0;
`endif
            end

            if (state == IDLE) begin
                spks <= 1'b0;
                cnt  <= (apply && !pend_rest) ? pend_code : ALL_ONES;
            end else if (full) begin
                if (apply) begin
                    // The apply edge replaces the toggle: the level holds, only the period changes.
                    cnt <= pend_rest ? ALL_ONES : pend_code;
                    if (pend_rest) begin
                        spks <= 1'b0;
                    end
                end else begin
                    cnt <= cur_code;
                    if (oct_wrap) begin
                        spks <= ~spks;
                    end
`ifdef TONE_OCTAVE_EN
                    oct_cnt <= oct_wrap ? 3'd0 : oct_cnt + 3'd1;
`endif
                end
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_note_tone_gen.sv
// tb/tb_note_tone_gen.sv - Self-checking bench for note_tone_gen
module tb_note_tone_gen;

    localparam int CODE_W = 11;
    localparam logic [16*CODE_W-1:0] FULL_TABLE = {
        11'h6C0, 11'h69A, 11'h684, 11'h656, 11'h640, 11'h606, 11'h5C8, 11'h582,
        11'h40C, 11'h390, 11'h305, 11'h69A, 11'h684, 11'h656, 11'h640, 11'h7FF};

    typedef struct {
        int idx;
        int oct;
        int half;
        int cur;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       note_ld = 1'b0;
    logic [3:0] note_idx = '0;
    logic [1:0] oct = '0;
    logic       spks;
    logic       tone_act;
    logic       note_ack;
    logic [3:0] cur_idx;

    logic       rst12 = 1'b1;
    logic       ld12 = 1'b0;
    logic [3:0] idx12 = '0;
    logic [1:0] oct12 = '0;
    logic       spks12;
    logic       act12;
    logic       ack12;
    logic [3:0] cur12;

    int checks = 0;
    int errors = 0;

    int codes[16] = '{'h7FF, 'h640, 'h656, 'h684, 'h69A, 'h305, 'h390, 'h40C,
                      'h582, 'h5C8, 'h606, 'h640, 'h656, 'h684, 'h69A, 'h6C0};

    bit m_on = 0;
    bit m_run = 0;
    bit m_spk = 0;
    bit m_ack = 0;
    bit m_pend = 0;
    int m_cur = 0;
    int m_pidx = 0;
    int m_poct = 0;
    int m_oct = 0;
    int m_left = 0;
    int m_fulls = 0;

    vec_t vecs[$];

    always #5 clk = ~clk;

    note_tone_gen dut (
        .clk(clk), .rst(rst), .note_ld(note_ld), .note_idx(note_idx),
`ifdef TONE_OCTAVE_EN
        .oct(oct),
`endif
        .spks(spks), .tone_act(tone_act), .note_ack(note_ack), .cur_idx(cur_idx)
    );

    note_tone_gen #(.NOTES(12), .IDX_W(4), .CODE_W(CODE_W), .TABLE(FULL_TABLE[12*CODE_W-1:0])) dut12 (
        .clk(clk), .rst(rst12), .note_ld(ld12), .note_idx(idx12),
`ifdef TONE_OCTAVE_EN
        .oct(oct12),
`endif
        .spks(spks12), .tone_act(act12), .note_ack(ack12), .cur_idx(cur12)
    );

    // Reference: tracks cycles left until the next period boundary and boundaries since the last toggle.
    task automatic mdl_step();
        bit full;
        bit apply;
        bit prest;
        int pcode;
        if (rst) begin
            m_run = 0; m_spk = 0; m_ack = 0; m_pend = 0; m_cur = 0;
            m_pidx = 0; m_poct = 0; m_oct = 0; m_left = 0; m_fulls = 0;
            m_on = 1;
            return;
        end
        full  = m_run && (m_left == 1);
        apply = m_pend && (!m_run || full);
        pcode = codes[m_pidx];
        prest = (pcode == 2047);
        if (m_run) begin
            if (apply) begin
                if (prest) begin
                    m_run = 0;
                    m_spk = 0;
                end else begin
                    m_left  = 2048 - pcode;
                    m_fulls = 0;
                end
            end else if (full) begin
                m_left = 2048 - codes[m_cur];
                m_fulls++;
                if (m_fulls == (1 << m_oct)) begin
                    m_spk   = !m_spk;
                    m_fulls = 0;
                end
            end else begin
                m_left--;
            end
        end else if (apply && !prest) begin
            m_run   = 1;
            m_left  = 2048 - pcode;
            m_fulls = 0;
        end
        m_ack = apply;
        if (apply) begin
            m_cur = m_pidx;
            m_oct = m_poct;
        end
        if (note_ld) begin
            m_pend = 1;
            m_pidx = int'(note_idx);
`ifdef TONE_OCTAVE_EN
            m_poct = int'(oct);
`else
            m_poct = 0;
`endif
        end else if (apply) begin
            m_pend = 0;
        end
    endtask

    initial forever begin
        @(posedge clk);
        mdl_step();
    end

    initial forever begin
        logic [6:0] got;
        logic [6:0] exp;
        @(negedge clk);
        if (m_on && errors < 40) begin
            got = {spks, tone_act, note_ack, cur_idx};
            exp = {m_spk, m_run, m_ack, 4'(m_cur)};
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL model t=%0t: got spks/act/ack/cur=%b/%b/%b/%0d, expected %b/%b/%b/%0d",
                         $time, spks, tone_act, note_ack, cur_idx, m_spk, m_run, m_ack, m_cur);
            end
        end
    end

    function automatic vec_t mkv(input int idx, input int o, input int half, input int cur);
        vec_t v;
        v.idx = idx; v.oct = o; v.half = half; v.cur = cur;
        return v;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic wait_toggle(input bit sel, output int n);
        logic lvl;
        lvl = sel ? spks12 : spks;
        n = 0;
        forever begin
            @(negedge clk);
            n++;
            if ((sel ? spks12 : spks) !== lvl) break;
            if (n >= 20000) begin
                n = -1;
                break;
            end
        end
    endtask

    task automatic wait_ack(input bit sel, output int n);
        n = 0;
        forever begin
            @(negedge clk);
            n++;
            if ((sel ? ack12 : note_ack) === 1'b1) break;
            if (n >= 5000) begin
                n = -1;
                break;
            end
        end
    endtask

    task automatic load(input int idx, input int o);
        note_ld = 1'b1; note_idx = 4'(idx); oct = 2'(o);
        @(negedge clk);
        note_ld = 1'b0;
    endtask

    task automatic load12(input int idx, input int o);
        ld12 = 1'b1; idx12 = 4'(idx); oct12 = 2'(o);
        @(negedge clk);
        ld12 = 1'b0;
    endtask

    task automatic pulse_rst();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        int n;
        int acks;
        vec_t v;

        vecs.push_back(mkv(1, 0, 448, 1));
        vecs.push_back(mkv(2, 0, 426, 2));
        vecs.push_back(mkv(15, 0, 320, 15));
        vecs.push_back(mkv(5, 0, 1275, 5));
        vecs.push_back(mkv(8, 0, 638, 8));
        vecs.push_back(mkv(0, 0, 0, 0));
`ifdef TONE_OCTAVE_EN
        vecs.push_back(mkv(1, 1, 896, 1));
        vecs.push_back(mkv(15, 3, 2560, 15));
`endif

        repeat (3) @(negedge clk);
        rst = 1'b0;
        rst12 = 1'b0;
        chk("reset_spks", spks, 0);
        chk("reset_act", tone_act, 0);
        chk("reset_ack", note_ack, 0);
        chk("reset_cur", cur_idx, 0);
        repeat (200) @(negedge clk);
        chk("idle_spks", spks, 0);
        chk("idle_act", tone_act, 0);
        chk("idle_cur", cur_idx, 0);

        foreach (vecs[i]) begin
            v = vecs[i];
            pulse_rst();
            load(v.idx, v.oct);
            wait_ack(0, n);
            chk("vec_ack_latency", n, 1);
            chk("vec_cur_idx", cur_idx, v.cur);
            chk("vec_tone_act", tone_act, (v.half != 0) ? 1 : 0);
            if (v.half != 0) begin
                wait_toggle(0, n);
                chk("vec_first_half", n, v.half);
                wait_toggle(0, n);
                chk("vec_second_half", n, v.half);
            end else begin
                repeat (300) @(negedge clk);
                chk("vec_rest_spks", spks, 0);
            end
        end

        // Mid-period change, then a rest, then a new note from silence.
        pulse_rst();
        load(1, 0);
        wait_ack(0, n);
        wait_toggle(0, n);
        chk("mid_half_idx1", n, 448);
        repeat (100) @(negedge clk);
        load(5, 0);
        wait_ack(0, n);
        chk("mid_ack_delay", n, 347);
        chk("mid_level_kept", spks, 1);
        chk("mid_cur", cur_idx, 5);
        wait_toggle(0, n);
        chk("mid_half_a", n, 1275);
        wait_toggle(0, n);
        chk("mid_half_b", n, 1275);
        load(0, 0);
        wait_ack(0, n);
        chk("rest_ack_delay", n, 1274);
        chk("rest_spks", spks, 0);
        chk("rest_act", tone_act, 0);
        chk("rest_cur", cur_idx, 0);
        load(15, 0);
        wait_ack(0, n);
        chk("after_rest_ack", n, 1);
        wait_toggle(0, n);
        chk("after_rest_half", n, 320);
        chk("after_rest_cur", cur_idx, 15);

        // Load landing exactly on a boundary while another note is still pending.
        pulse_rst();
        load(1, 0);
        wait_ack(0, n);
        wait_toggle(0, n);
        repeat (10) @(negedge clk);
        load(2, 0);
        repeat (436) @(negedge clk);
        load(8, 0);
        chk("same_edge_ack", note_ack, 1);
        chk("same_edge_cur_old", cur_idx, 2);
        wait_ack(0, n);
        chk("same_edge_next_ack", n, 426);
        chk("same_edge_cur_new", cur_idx, 8);

        // Reset mid-period, and reset discarding a pending note.
        repeat (50) @(negedge clk);
        pulse_rst();
        chk("midrst_spks", spks, 0);
        chk("midrst_act", tone_act, 0);
        chk("midrst_ack", note_ack, 0);
        chk("midrst_cur", cur_idx, 0);
        load(8, 0);
        pulse_rst();
        repeat (20) @(negedge clk);
        chk("discard_act", tone_act, 0);
        chk("discard_cur", cur_idx, 0);

        // NOTES=12 instance: clamping and last-load-wins.
        rst12 = 1'b1;
        @(negedge clk);
        rst12 = 1'b0;
        load12(1, 0);
        wait_ack(1, n);
        chk("n12_ack_latency", n, 1);
        wait_toggle(1, n);
        chk("n12_half_idx1", n, 448);
        repeat (50) @(negedge clk);
        load12(2, 0);
        repeat (20) @(negedge clk);
        load12(3, 0);
        acks = 0;
        repeat (500) begin
            @(negedge clk);
            if (ack12 === 1'b1) acks++;
        end
        chk("n12_single_ack", acks, 1);
        chk("n12_cur_last", cur12, 3);
        wait_toggle(1, n);
        wait_toggle(1, n);
        chk("n12_half_idx3", n, 380);
        load12(13, 0);
        wait_ack(1, n);
        chk("n12_clamp_ack", n, 379);
        chk("n12_clamp_cur", cur12, 11);
        wait_toggle(1, n);
        chk("n12_clamp_half", n, 448);

        // Random loads and resets checked against the reference every cycle.
        pulse_rst();
        for (int c = 0; c < 12000; c++) begin
            if ($urandom_range(0, 999) == 0) begin
                rst = 1'b1;
            end else if ($urandom_range(0, 249) == 0) begin
                note_ld = 1'b1;
                note_idx = 4'($urandom_range(0, 15));
                oct = 2'($urandom_range(0, 3));
            end
            @(negedge clk);
            rst = 1'b0;
            note_ld = 1'b0;
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
